// File: rtl/addr_gen_2d_pkg.sv
// Shared types for the 2-D address sequencer: FSM states, sweep modes and counter sizing.
package addr_gen_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_DONE} state_t;

    localparam logic MODE_ROW = 1'b0;
    localparam logic MODE_COL = 1'b1;

    // Counters must be able to hold their own limit value, not just limit-1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/addr_gen_2d_if.sv
// Controller-side handshake and RAM address bus of addr_gen_2d.
// ADDR_GEN_2D_REVERSE_EN adds the i_reverse request bit.
interface addr_gen_2d_if #(parameter int ADDR_WIDTH = 12);

    logic                  i_start;
    logic                  i_en;
    logic                  i_mode;
    logic [ADDR_WIDTH-1:0] i_base;
`ifdef ADDR_GEN_2D_REVERSE_EN
    logic                  i_reverse;
`endif
    logic [ADDR_WIDTH-1:0] o_addr;
    logic                  o_valid;
    logic                  o_last_inner;
    logic                  o_done;
    logic                  o_busy;

    modport master (
`ifdef ADDR_GEN_2D_REVERSE_EN
        output i_reverse,
`endif
        output i_start, i_en, i_mode, i_base,
        input  o_addr, o_valid, o_last_inner, o_done, o_busy
    );

    modport slave (
`ifdef ADDR_GEN_2D_REVERSE_EN
        input  i_reverse,
`endif
        input  i_start, i_en, i_mode, i_base,
        output o_addr, o_valid, o_last_inner, o_done, o_busy
    );

endinterface

// File: rtl/addr_gen_2d_cnt.sv
// Enabled up/down counter with runtime limit; wraps to its start value after the terminal count.
module addr_gen_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             down,
    input  logic [WIDTH-1:0] limit,
    output logic             term
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] last;

    always_comb begin
        first = down ? limit - ONE : '0;
        last  = down ? '0 : limit - ONE;
    end

    assign term = (count == last);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= first;
        else if (en)
            count <= term ? first : (down ? count - ONE : count + ONE);
    end

endmodule

// File: rtl/addr_gen_2d.sv
// Row-/column-major 2-D address sequencer with inter-line bubbles for MAC drain.
// Optional macro ADDR_GEN_2D_REVERSE_EN: descending outer index (BPTT order).
module addr_gen_2d
    import addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int ROWS       = 53,
    parameter int COLS       = 7,
    parameter int GAP        = 1
) (
    input  logic         clk,
    input  logic         rst,
    addr_gen_2d_if.slave bus
);

    localparam int CW = cnt_width(ROWS, COLS, GAP);
    localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
    localparam logic [CW-1:0] COLS_C = CW'(COLS);
    localparam logic [CW-1:0] GAP_C  = CW'((GAP > 0) ? GAP : 1);

    localparam logic [ADDR_WIDTH-1:0] ONE_A        = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] COLS_A       = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW_OFS = ADDR_WIDTH'((ROWS - 1) * COLS);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL_OFS = ADDR_WIDTH'(COLS - 1);

    state_t                state;
    logic                  mode_r;
    logic                  rev_r;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] line;

    logic                  rev_in;
    logic                  mode_sel;
    logic                  rev_sel;
    logic [CW-1:0]         inner_len;
    logic [CW-1:0]         outer_len;
    logic [ADDR_WIDTH-1:0] inner_step;
    logic [ADDR_WIDTH-1:0] outer_step;
    logic [ADDR_WIDTH-1:0] line_next;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  start_ok;
    logic                  beat;
    logic                  inner_term;
    logic                  outer_term;
    logic                  gap_term;

`ifdef ADDR_GEN_2D_REVERSE_EN
    assign rev_in = bus.i_reverse;
`else
    assign rev_in = 1'b0;
`endif

    // In IDLE the counters are cleared against the live request so their start value matches the latched mode.
    always_comb begin
        mode_sel   = (state == ST_IDLE) ? bus.i_mode : mode_r;
        rev_sel    = (state == ST_IDLE) ? rev_in : rev_r;
        inner_len  = (mode_sel == MODE_COL) ? ROWS_C : COLS_C;
        outer_len  = (mode_sel == MODE_COL) ? COLS_C : ROWS_C;
        inner_step = (mode_r == MODE_COL) ? COLS_A : ONE_A;
        outer_step = (mode_r == MODE_COL) ? ONE_A : COLS_A;
        line_next  = rev_r ? line - outer_step : line + outer_step;
        start_addr = bus.i_base;
        if (rev_in)
            start_addr = bus.i_base + ((bus.i_mode == MODE_COL) ? LAST_COL_OFS : LAST_ROW_OFS);
    end

    assign start_ok = (state == ST_IDLE) && bus.i_start;
    assign beat     = (state == ST_RUN) && bus.i_en;

    addr_gen_cnt #(.WIDTH(CW)) u_inner (
        .clk(clk), .rst(rst), .clr(start_ok), .en(beat),
        .down(1'b0), .limit(inner_len), .term(inner_term)
    );

    addr_gen_cnt #(.WIDTH(CW)) u_outer (
        .clk(clk), .rst(rst), .clr(start_ok), .en(beat && inner_term),
        .down(rev_sel), .limit(outer_len), .term(outer_term)
    );

    addr_gen_cnt #(.WIDTH(CW)) u_gap (
        .clk(clk), .rst(rst), .clr(start_ok), .en((state == ST_GAP) && bus.i_en),
        .down(1'b0), .limit(GAP_C), .term(gap_term)
    );

    // The address only ever steps by a constant; line holds the start of the current inner sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr   <= '0;
            line   <= '0;
            mode_r <= MODE_ROW;
            rev_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        mode_r <= bus.i_mode;
                        rev_r  <= rev_in;
                        addr   <= start_addr;
                        line   <= start_addr;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.i_en) begin
                        if (!inner_term) begin
                            addr <= addr + inner_step;
                        end else if (outer_term) begin
                            state <= ST_DONE;
                        end else if (GAP > 0) begin
                            state <= ST_GAP;
                        end else begin
                            addr <= line_next;
                            line <= line_next;
                        end
                    end
                end
                ST_GAP: begin
                    if (bus.i_en && gap_term) begin
                        addr  <= line_next;
                        line  <= line_next;
                        state <= ST_RUN;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_addr       = addr;
    assign bus.o_valid      = beat;
    assign bus.o_last_inner = beat && inner_term;
    assign bus.o_done       = (state == ST_DONE);
    assign bus.o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_addr_gen_2d.sv
// Directed bench for addr_gen_2d: a GAP=0 and a GAP=2 instance (3x4 matrix) share one stimulus stream.
module tb_addr_gen_2d;

`ifdef ADDR_GEN_2D_REVERSE_EN
    localparam logic REV_BIT = 1'b1;
`else
    localparam logic REV_BIT = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        en    = 1'b0;
    logic        mode  = 1'b0;
    logic        rev   = 1'b0;
    logic [11:0] base  = '0;
    int          cyc   = 0;
    int          t0    = 0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addr_gen_2d_if #(.ADDR_WIDTH(12)) if0 ();
    addr_gen_2d_if #(.ADDR_WIDTH(12)) if2 ();

    assign if0.i_start = start;
    assign if0.i_en    = en;
    assign if0.i_mode  = mode;
    assign if0.i_base  = base;
    assign if2.i_start = start;
    assign if2.i_en    = en;
    assign if2.i_mode  = mode;
    assign if2.i_base  = base;
`ifdef ADDR_GEN_2D_REVERSE_EN
    assign if0.i_reverse = rev;
    assign if2.i_reverse = rev;
`endif

    addr_gen_2d #(.ADDR_WIDTH(12), .ROWS(3), .COLS(4), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    addr_gen_2d #(.ADDR_WIDTH(12), .ROWS(3), .COLS(4), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    // Hand-derived beat orders for a 3x4 matrix at base 0.
    logic [11:0] seq_row [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    logic [11:0] seq_col [12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
    logic [11:0] seq_rev [12] = '{8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};

    logic [11:0] exp_seq [12];
    logic [11:0] exp_last[$];
    int          gap_extra;

    logic [11:0] q0[$], q2[$], l0[$], l2[$], bub2[$];
    logic [11:0] last2;
    int          done0_cnt, done2_cnt, done0_cyc, done2_cyc;
    logic        busy0_after, busy2_after;
    bit          capture   = 1'b0;
    bit          chk_stall = 1'b0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_expect(input logic m, input logic [11:0] b, input logic rv);
        for (int i = 0; i < 12; i++)
            exp_seq[i] = (rv ? seq_rev[i] : (m ? seq_col[i] : seq_row[i])) + b;
        exp_last.delete();
        if (rv) begin
            exp_last.push_back(12'd11 + b); exp_last.push_back(12'd7 + b); exp_last.push_back(12'd3 + b);
        end else if (m) begin
            exp_last.push_back(12'd8 + b);  exp_last.push_back(12'd9 + b);
            exp_last.push_back(12'd10 + b); exp_last.push_back(12'd11 + b);
        end else begin
            exp_last.push_back(12'd3 + b); exp_last.push_back(12'd7 + b); exp_last.push_back(12'd11 + b);
        end
        gap_extra = m ? 6 : 4;
    endtask

    task automatic clear_tracking();
        q0.delete(); q2.delete(); l0.delete(); l2.delete(); bub2.delete();
        last2       = '0;
        done0_cnt   = 0;
        done2_cnt   = 0;
        done0_cyc   = -1;
        done2_cyc   = -1;
        busy0_after = 1'b1;
        busy2_after = 1'b1;
    endtask

    always @(negedge clk) begin
        if (capture) begin
            if (if0.o_valid)
                q0.push_back(if0.o_addr);
            else if (chk_stall && if0.o_busy && !if0.o_done && q0.size() < 12)
                check_output("stall_hold", if0.o_addr, exp_seq[q0.size()]);
            if (if0.o_last_inner) l0.push_back(if0.o_addr);
            if (done0_cnt > 0 && cyc == done0_cyc + 1) busy0_after = if0.o_busy;
            if (if0.o_done) begin done0_cnt++; done0_cyc = cyc; end

            if (if2.o_valid) begin
                q2.push_back(if2.o_addr);
                last2 = if2.o_addr;
            end else if (if2.o_busy && !if2.o_done && en) begin
                bub2.push_back(last2);
            end
            if (if2.o_last_inner) l2.push_back(if2.o_addr);
            if (done2_cnt > 0 && cyc == done2_cyc + 1) busy2_after = if2.o_busy;
            if (if2.o_done) begin done2_cnt++; done2_cyc = cyc; end
        end
    end

    // One full sweep; request inputs are scrambled after the start pulse to prove they were latched.
    task automatic apply_stimulus(input logic m, input logic [11:0] b, input logic rv,
                                  input bit toggle, input bit start_at_done);
        load_expect(m, b, rv);
        clear_tracking();
        chk_stall = toggle;
        capture   = 1'b1;
        @(posedge clk); #1;
        mode = m; base = b; rev = rv; en = 1'b1; start = 1'b1;
        t0 = cyc;
        for (int k = 1; k < 200; k++) begin
            @(posedge clk); #1;
            start = (toggle && (k % 5 == 2) && k < 20) || (start_at_done && k == 13);
            mode  = ~m;
            base  = ~b;
            rev   = ~rv;
            en    = toggle ? (k % 2 == 0) : 1'b1;
            if (done0_cnt > 0 && done2_cnt > 0 && cyc > done0_cyc + 2 && cyc > done2_cyc + 2)
                break;
        end
        start = 1'b0;
        en    = 1'b1;
        capture = 1'b0;
    endtask

    task automatic check_sweep(input string name, input bit toggle);
        check_output({name, "/beats0"}, q0.size(), 12);
        check_output({name, "/beats2"}, q2.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < q0.size()) check_output($sformatf("%s/addr0[%0d]", name, i), q0[i], exp_seq[i]);
            if (i < q2.size()) check_output($sformatf("%s/addr2[%0d]", name, i), q2[i], exp_seq[i]);
        end
        check_output({name, "/last0_n"}, l0.size(), exp_last.size());
        check_output({name, "/last2_n"}, l2.size(), exp_last.size());
        for (int i = 0; i < exp_last.size(); i++) begin
            if (i < l0.size()) check_output($sformatf("%s/last0[%0d]", name, i), l0[i], exp_last[i]);
            if (i < l2.size()) check_output($sformatf("%s/last2[%0d]", name, i), l2[i], exp_last[i]);
        end
        check_output({name, "/done0_cnt"}, done0_cnt, 1);
        check_output({name, "/done2_cnt"}, done2_cnt, 1);
        check_output({name, "/busy0_after"}, busy0_after, 0);
        check_output({name, "/busy2_after"}, busy2_after, 0);
        if (!toggle) begin
            check_output({name, "/done0_cyc"}, done0_cyc, t0 + 13);
            check_output({name, "/done2_cyc"}, done2_cyc, t0 + 13 + gap_extra);
            check_output({name, "/bubbles_n"}, bub2.size(), 2 * (exp_last.size() - 1));
            for (int j = 0; j < bub2.size(); j++)
                check_output($sformatf("%s/bubble[%0d]", name, j), bub2[j], exp_last[j / 2]);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst/addr0", if0.o_addr, 0);
        check_output("rst/valid0", if0.o_valid, 0);
        check_output("rst/last0", if0.o_last_inner, 0);
        check_output("rst/done0", if0.o_done, 0);
        check_output("rst/busy0", if0.o_busy, 0);
        check_output("rst/busy2", if2.o_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        apply_stimulus(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
        check_sweep("row", 1'b0);
        apply_stimulus(1'b1, 12'd0, 1'b0, 1'b0, 1'b0);
        check_sweep("col", 1'b0);
        apply_stimulus(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
        check_sweep("stall", 1'b1);
        apply_stimulus(1'b0, 12'd4094, 1'b0, 1'b0, 1'b0);
        check_sweep("wrap", 1'b0);

        // Abort a sweep while address 5 is on the bus.
        load_expect(1'b0, 12'd0, 1'b0);
        clear_tracking();
        chk_stall = 1'b0;
        capture   = 1'b1;
        @(posedge clk); #1;
        mode = 1'b0; base = '0; rev = 1'b0; en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_output("abort/addr_before", if0.o_addr, 5);
        check_output("abort/valid_before", if0.o_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort/addr0", if0.o_addr, 0);
        check_output("abort/valid0", if0.o_valid, 0);
        check_output("abort/last0", if0.o_last_inner, 0);
        check_output("abort/done0", if0.o_done, 0);
        check_output("abort/busy0", if0.o_busy, 0);
        check_output("abort/addr2", if2.o_addr, 0);
        check_output("abort/busy2", if2.o_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_output("abort/no_done0", done0_cnt, 0);
        check_output("abort/no_done2", done2_cnt, 0);
        capture = 1'b0;

        apply_stimulus(1'b0, 12'd0, REV_BIT, 1'b0, 1'b0);
        check_sweep("clean", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
